// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state codes, frame size and the parity helper.
package ps2_pkg;

    typedef logic [2:0] ps2_state_t;

    localparam ps2_state_t ST_IDLE      = 3'd0;
    localparam ps2_state_t ST_INHIBIT   = 3'd1;
    localparam ps2_state_t ST_REQ       = 3'd2;
    localparam ps2_state_t ST_BITS      = 3'd3;
    localparam ps2_state_t ST_ACK       = 3'd4;
    localparam ps2_state_t ST_WAIT_IDLE = 3'd5;

    localparam int unsigned PS2_FRAME_BITS = 10;

    // Odd parity: the returned bit makes the total count of ones in byte+parity odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_fall_detect.sv
// Registered falling-edge detector on a debounced PS/2 clock level.
module ps2_fall_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk_in,
    output logic fall
);

    logic clk_prev_q;

    // Resets high so a line that is already low out of reset is not seen as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_prev_q <= 1'b1;
        end else begin
            clk_prev_q <= ps2_clk_in;
        end
    end

    assign fall = clk_prev_q & ~ps2_clk_in;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 10 clocked bits, ACK check.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 12000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int unsigned MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                         INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ps2_state_t                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d, cnt_inc;
    logic [PS2_FRAME_BITS-1:0] frame_q, frame_d;
    logic [3:0]                bit_cnt_q, bit_cnt_d;
    logic                      ack_q, ack_d;
    logic                      clk_oe_q, clk_oe_d;
    logic                      data_oe_q, data_oe_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic                      fall;
    logic                      on_link;

    ps2_fall_detect u_fall (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk_in (ps2_clk_in),
        .fall       (fall)
    );

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    // Device-clocked phases are guarded by the timeout, except while a result pulse is out.
    assign on_link = (state_q inside {ST_REQ, ST_BITS, ST_ACK, ST_WAIT_IDLE}) &&
                     !(done_q || err_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        frame_d   = frame_q;
        bit_cnt_d = bit_cnt_q;
        ack_d     = ack_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    frame_d   = {1'b1, odd_parity(tx_data), tx_data};
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    ack_d     = 1'b0;
                    clk_oe_d  = 1'b1;
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_REQ;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_REQ, ST_BITS: begin
                if (fall) begin
                    data_oe_d = ~frame_q[0];
                    frame_d   = {1'b0, frame_q[PS2_FRAME_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    state_d   = (bit_cnt_q == 4'd9) ? ST_ACK : ST_BITS;
                end
            end
            ST_ACK: begin
                if (fall) begin
                    ack_d   = ~ps2_data_in;
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                // Stay one extra cycle so tx_ready rises after the pulse, not with it.
                if (done_q || err_q) begin
                    state_d = ST_IDLE;
                end else if (ps2_clk_in && ps2_data_in) begin
                    done_d = ack_q;
                    err_d  = ~ack_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (on_link) begin
            if (fall) begin
                cnt_d = '0;
            end else if (cnt_q == TMO_LAST) begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                done_d    = 1'b0;
                err_d     = 1'b1;
                state_d   = ST_WAIT_IDLE;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            frame_q   <= '0;
            bit_cnt_q <= '0;
            ack_q     <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            frame_q   <= frame_d;
            bit_cnt_q <= bit_cnt_d;
            ack_q     <= ack_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign tx_ready    = (state_q == ST_IDLE);
    assign busy        = ~tx_ready;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_done     = done_q;
    assign tx_err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device, frame model and per-cycle output checks.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TMO  = 500;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_line, ps2_data_line;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int done_cnt = 0, err_cnt = 0, hs_cnt = 0, last_fall = 0;

    // Open-drain wired-AND of host and device drivers.
    assign ps2_clk_line  = ~ps2_clk_oe & ~dev_clk_low;
    assign ps2_data_line = ~ps2_data_oe & ~dev_data_low;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_line),
        .ps2_data_in (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle count and handshake tally sampled at the active edge.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst_n && tx_valid && tx_ready) hs_cnt++;
    end

    // Per-cycle compare against protocol rules.
    initial begin
        int  inh_cnt;
        logic prev_clk_oe, prev_pulse;
        inh_cnt = 0; prev_clk_oe = 1'b0; prev_pulse = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                inh_cnt = 0; prev_clk_oe = 1'b0; prev_pulse = 1'b0;
            end else begin
                check("busy_is_not_ready", busy, !tx_ready);
                if (tx_ready) check("idle_lines_released", ps2_clk_oe | ps2_data_oe, 0);
                if (tx_done || tx_err) begin
                    check("done_err_exclusive", tx_done & tx_err, 0);
                    check("ready_low_during_pulse", tx_ready, 0);
                end
                if (prev_pulse) check("ready_after_pulse", tx_ready, 1);
                if (tx_done) done_cnt++;
                if (tx_err) err_cnt++;
                if (ps2_clk_oe) begin
                    inh_cnt++;
                end else if (prev_clk_oe) begin
                    check("inhibit_length", inh_cnt, INH);
                    check("start_bit_with_release", ps2_data_oe, 1);
                    inh_cnt = 0;
                end
                prev_clk_oe = ps2_clk_oe;
                prev_pulse  = tx_done | tx_err;
            end
        end
    end

    task automatic start_req(input logic [7:0] d);
        int h0, t;
        h0 = hs_cnt;
        @(negedge clk);
        tx_data = d; tx_valid = 1'b1;
        t = 0;
        while (hs_cnt == h0 && t < 100) begin @(negedge clk); t++; end
        check("handshake", hs_cnt - h0, 1);
        check("clk_oe_after_handshake", ps2_clk_oe, 1);
        tx_valid = 1'b0;
        tx_data  = ~d;
    endtask

    // Device: waits for request-to-send, clocks nfalls falls, checks each bit against
    // the frame built from d; on fall 11 pulls data low when ack is set.
    task automatic device(input logic [7:0] d, input bit ack, input int nfalls,
                          output logic [9:0] cap);
        int t, ones;
        logic [9:0] fr;
        cap = '0;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        fr = {1'b1, ((ones % 2) == 0), d};
        t = 0;
        while (!(ps2_clk_line && !ps2_data_line && !ps2_clk_oe) && t < 3000) begin
            @(negedge clk); t++;
        end
        check("request_to_send_seen", t < 3000, 1);
        for (int k = 1; k <= nfalls && k <= 11; k++) begin
            repeat (HALF) @(negedge clk);
            if (k == 11 && ack) dev_data_low = 1'b1;
            dev_clk_low = 1'b1;
            last_fall = cyc;
            repeat (HALF) @(negedge clk);
            if (k <= 10) begin
                cap[k-1] = ps2_data_line;
                check($sformatf("frame_bit%0d_of_%02h", k, d), ps2_data_line, fr[k-1]);
            end
            dev_clk_low = 1'b0;
            if (k == 11) begin
                repeat (HALF / 2) @(negedge clk);
                dev_data_low = 1'b0;
            end
        end
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (!tx_ready && t < 1500) begin @(negedge clk); t++; end
        check("ready_returns", tx_ready, 1);
        @(negedge clk);
    endtask

    task automatic do_xfer(input logic [7:0] d, input bit ack, output logic [9:0] cap);
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        start_req(d);
        device(d, ack, 11, cap);
        wait_ready();
        check($sformatf("done_pulses_%02h", d), done_cnt - d0, int'(ack));
        check($sformatf("err_pulses_%02h", d), err_cnt - e0, int'(!ack));
        check("released_after_xfer", ps2_clk_oe | ps2_data_oe, 0);
    endtask

    initial begin
        logic [9:0] cap;
        logic [7:0] d;
        bit         a;
        int         t, d0, e0, h0, dly;

        repeat (3) @(negedge clk);
        check("reset_tx_ready", tx_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_clk_oe", ps2_clk_oe, 0);
        check("reset_data_oe", ps2_data_oe, 0);
        check("reset_tx_done", tx_done, 0);
        check("reset_tx_err", tx_err, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_xfer(8'hED, 1'b1, cap);
        check("frame_ED", int'(cap), 10'h3ED);
        do_xfer(8'hF4, 1'b1, cap);
        check("parity_F4", int'(cap[8]), 0);
        check("frame_F4", int'(cap), 10'h2F4);
        do_xfer(8'h5A, 1'b0, cap);

        // Device goes silent after fall 4.
        e0 = err_cnt; d0 = done_cnt;
        start_req(8'h3C);
        device(8'h3C, 1'b1, 4, cap);
        t = 0;
        while (err_cnt == e0 && t < 1500) begin @(negedge clk); t++; end
        dly = cyc - last_fall;
        check("timeout_err_pulse", err_cnt - e0, 1);
        check("timeout_delay_in_window", (dly >= TMO - 5 && dly <= TMO + 10), 1);
        wait_ready();
        check("timeout_no_done", done_cnt - d0, 0);
        check("timeout_released", ps2_clk_oe | ps2_data_oe, 0);

        // Reset in the middle of the data bits (bit 4 of 0xED is 0, so data is pulled).
        start_req(8'hED);
        device(8'hED, 1'b1, 5, cap);
        repeat (3) @(negedge clk);
        check("pre_reset_data_oe", ps2_data_oe, 1);
        check("pre_reset_busy", busy, 1);
        e0 = err_cnt; d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_clk_oe", ps2_clk_oe, 0);
        check("async_reset_data_oe", ps2_data_oe, 0);
        check("async_reset_ready", tx_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_ready", tx_ready, 1);
        check("reset_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);

        // tx_valid held high with new data during a transfer.
        h0 = hs_cnt; d0 = done_cnt;
        @(negedge clk);
        tx_data = 8'hA5; tx_valid = 1'b1;
        t = 0;
        while (hs_cnt == h0 && t < 100) begin @(negedge clk); t++; end
        tx_data = 8'h66;
        device(8'hA5, 1'b1, 11, cap);
        check("held_first_byte", int'(cap[7:0]), 8'hA5);
        t = 0;
        while (hs_cnt < h0 + 2 && t < 1500) begin @(negedge clk); t++; end
        check("second_handshake", hs_cnt - h0, 2);
        check("first_done_before_second", done_cnt - d0, 1);
        tx_valid = 1'b0;
        device(8'h66, 1'b1, 11, cap);
        check("held_second_byte", int'(cap[7:0]), 8'h66);
        wait_ready();
        check("held_done_total", done_cnt - d0, 2);
        check("held_handshakes_total", hs_cnt - h0, 2);

        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom_range(0, 255));
            a = ($urandom_range(0, 3) != 0);
            do_xfer(d, a, cap);
            check("random_byte_seen", int'(cap[7:0]), int'(d));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got cycle %0d, expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable) from the FPGA to the attached keyboard over the shared PS/2 clock/data pair. It consumes the debounced line levels produced by the keyboard-input debouncer, and drives the lines open-drain through output-enable signals. While it owns the bus, the keyboard receiver path is told to ignore traffic via `busy`.

## Interface
Parameters:
- `INHIBIT_CYCLES`, 12000: cycles the clock line is held low before the start bit (≥100 µs at 100 MHz).
- `TIMEOUT_CYCLES`, 2000000: maximum cycles allowed between device clock falling edges before aborting (20 ms at 100 MHz).

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `tx_data` in 8: command byte, sampled on the handshake.
- `tx_valid` in 1: request to send `tx_data`.
- `tx_ready` out 1: high only in IDLE; a transfer starts when `tx_valid & tx_ready`.
- `ps2_clk_in` in 1: debounced PS/2 clock level.
- `ps2_data_in` in 1: debounced PS/2 data level.
- `ps2_clk_oe` out 1: 1 = pull clock line low, 0 = release.
- `ps2_data_oe` out 1: 1 = pull data line low, 0 = release.
- `busy` out 1: high in every state except IDLE.
- `tx_done` out 1: one-cycle pulse, byte sent and ACK received.
- `tx_err` out 1: one-cycle pulse, NACK or timeout.

## Operation
- Reset values: `ps2_clk_oe`=0, `ps2_data_oe`=0, `tx_ready`=1, `busy`=0, `tx_done`=0, `tx_err`=0. State is IDLE.
- Falling edge of PS/2 clock: `fall = clk_prev & ~ps2_clk_in`, where `clk_prev` is registered and resets to 1.
- Frame register (10 bits, shifted LSB first) = {stop=1, parity=~^tx_data (odd), tx_data[7:0]}. A 4-bit bit counter runs 0..10.
- States and transitions:
  - IDLE: both lines released. On handshake, latch the frame, clear the counters and go to INHIBIT.
  - INHIBIT: `ps2_clk_oe`=1. After INHIBIT_CYCLES cycles, set `ps2_data_oe`=1 (start bit) and go to REQ.
  - REQ: set `ps2_clk_oe`=0 while holding data low. Wait for the first `fall`.
  - BITS: on each `fall`, set `ps2_data_oe` = ~frame[0], shift the frame and increment the counter. Falls 1..8 carry data, fall 9 carries parity, and fall 10 carries stop (data released). After fall 10, go to ACK.
  - ACK: on the next `fall`, sample `ps2_data_in`. A value of 0 is an ACK; a value of 1 is a NACK (flag error). Go to WAIT_IDLE.
  - WAIT_IDLE: wait until `ps2_clk_in`=1 and `ps2_data_in`=1. Then pulse `tx_done` (ACK) or `tx_err` (NACK) and return to IDLE.
- Timeout:
  - The cycle counter clears on every `fall`.
  - In REQ, BITS, ACK or WAIT_IDLE, reaching TIMEOUT_CYCLES does three things: release both lines, pulse `tx_err`, and return to IDLE.
- `tx_done` and `tx_err` are never high together.
- `tx_valid` is ignored while `tx_ready`=0, and `tx_data` changes after the handshake have no effect.
- Asserting `rst_n` mid-transfer releases both lines immediately (asynchronously) and emits no pulse.
- The counter width is sized to max(INHIBIT_CYCLES, TIMEOUT_CYCLES). It saturates and never wraps.

## Timing
- The handshake cycle is followed by INHIBIT entry in the next cycle. `ps2_clk_oe` rises 1 cycle after the handshake.
- `ps2_clk_oe` stays high for exactly INHIBIT_CYCLES cycles. `ps2_data_oe` rises in the same cycle `ps2_clk_oe` falls.
- Data output updates 1 cycle after the registered `fall`. This is well inside the ~30 µs PS/2 low phase, even after the debouncer's ~20-cycle input delay.
- `tx_done`/`tx_err` assert 1 cycle after the idle condition (or timeout) is detected. `tx_ready` returns high in the following cycle.
- Minimum transaction is INHIBIT_CYCLES + 11 device clocks + the idle check.

## Structure
- Shared package `ps2_pkg`:
  - state enum (IDLE, INHIBIT, REQ, BITS, ACK, WAIT_IDLE);
  - constant `PS2_FRAME_BITS`=10;
  - function `odd_parity(byte)`.
- Sub-module `ps2_fall_detect`: registered falling-edge detector on the debounced clock. It is reusable by the keyboard receiver.

## Test plan
Bench settings: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=500, with a device model clocking at 1 fall per 40 cycles.
- Send 0xED with the device ACKing. Required response: clock held low for 20 cycles, then data driven 1,0,1,1,0,1,1,1, parity 1, stop released. Device pulls data low at fall 11, then `tx_done` pulses once.
- Send 0xF4. Required: parity bit 0 and `tx_done`.
- Device leaves data high at fall 11 (NACK). Required: `tx_err` pulses, `tx_done` stays 0, and both oe outputs read 0.
- Device stops clocking after fall 4. Required: 500 cycles later `tx_err` pulses, lines are released and `tx_ready`=1.
- Assert `rst_n` low during BITS. Required: both oe outputs go to 0 in the same cycle, with no done/err pulse, and `tx_ready`=1 after release.
- Hold `tx_valid` high with new data during a transfer. Required: it is ignored; a second byte is sent only after returning to IDLE.
